rst_sequencer: RTL
==================

// Module: rst_sequencer
// PURPOSE
//   Generates the block-level active-low resets consumed downstream.
//   Holds every domain in reset until the PLL/clock source reports lock, then keeps them
//   asserted for a minimum width. It then releases them one by one in a fixed order,
//   with a programmable gap between releases.
//   Re-sequences on lock loss or on a software reset request. Sits at the top of the
//   clock/reset tree, ahead of the per-domain reset synchronizers.
// PARAMETERS
//   NUM_DOMAINS  4   number of sequenced active-low reset outputs (>=1)
//   HOLD_CYCLES  16  minimum all-asserted width after lock, in CLK_I cycles (>=1)
//   STAGE_GAP    8   CLK_I cycles between successive domain releases (>=1)
//   LOCK_STAGES  2   synchronizer depth for LOCK_I (>=2)
//   CNT_W        localparam, $clog2(max(HOLD_CYCLES,STAGE_GAP)+1)
// PORTS
//   CLK_I       in   1            single clock, all logic on its rising edge
//   RST_I       in   1            asynchronous, active-high reset
//   LOCK_I      in   1            clock-source lock, asynchronous level
//   SWRST_I     in   1            software reset request, CLK_I-synchronous, 1-cycle pulse
//   NRST_O      out  NUM_DOMAINS  sequenced resets, active low, bit 0 released first
//   RST_BUSY_O  out  1            high while any NRST_O bit is low
//   REL_DONE_O  out  1            high when all domains are released (RUN state)
// BEHAVIOUR
//   - Reset: RST_I=1 forces these values immediately, without waiting for a clock edge:
//     NRST_O='0, RST_BUSY_O=1, REL_DONE_O=0, state=ASSERT, counters=0, lock sync='0.
//   - RST_I deassertion is sampled synchronously; the first active edge follows it.
//   - All outputs are registered; no combinational path from any input to any output.
//   - LOCK_I passes through a LOCK_STAGES flop synchronizer; lock_s is its last stage.
//   - FSM states, held in rst_seq_pkg::state_t:
//     ASSERT: NRST_O='0. The FSM moves to HOLD on the first edge where lock_s=1, and
//       clears cnt on that edge.
//     HOLD: NRST_O='0; cnt increments each cycle. On the edge where cnt==HOLD_CYCLES-1:
//       NRST_O[0]<=1, idx<=1, cnt<=0. The FSM then goes to RELEASE, or to RUN if
//       NUM_DOMAINS==1.
//     RELEASE: cnt increments each cycle. On the edge where cnt==STAGE_GAP-1:
//       NRST_O[idx]<=1, idx++, cnt<=0. The edge that releases bit NUM_DOMAINS-1 moves
//       the FSM to RUN.
//     RUN: NRST_O='1; REL_DONE_O=1 and RST_BUSY_O=0 are registered on the same edge as
//       the final release.
//   - Re-sequence: lock_s=0 or SWRST_I=1 in HOLD, RELEASE or RUN forces ASSERT at the
//     next edge. On that edge: NRST_O<='0, REL_DONE_O<=0, RST_BUSY_O<=1, cnt<=0, idx<=0.
//     This applies even if it coincides with a release edge; the re-sequence wins.
//   - SWRST_I in ASSERT is ignored. A SWRST_I given while lock_s=0 does not extend
//     HOLD later.
//   - Release order is strictly ascending; a higher bit never deasserts before a lower one.
//   - Assertion is always simultaneous for all bits.
//   - Latency, with LOCK_I already high at RST_I deassert:
//     HOLD entry = edge LOCK_STAGES+1.
//     NRST_O[k] rises at edge LOCK_STAGES+1+HOLD_CYCLES+k*STAGE_GAP.
//   - Counters saturate by construction (cleared on match); idx never exceeds NUM_DOMAINS.
//   - Elaboration-time $error if any parameter is below its minimum.
// STRUCTURE
//   - rst_seq_pkg holds:
//     - state_t enum {ASSERT, HOLD, RELEASE, RUN}
//     - parameter-check functions
//   - Sub-module lock_synchronizer (params STAGES; ports CLK_I, RST_I, D_I, Q_O):
//     - plain level synchronizer with async active-high clear
//     - reused for other slow status inputs.
//   - Top: FSM, cnt[CNT_W-1:0], idx[$clog2(NUM_DOMAINS+1)-1:0], output register.
// TESTING   (defaults: 4 domains, HOLD=16, GAP=8, LOCK_STAGES=2; edges counted after RST_I low)
//   1. Power-up with LOCK_I=1 throughout.
//      Expect NRST_O steps 0000->0001@19->0011@27->0111@35->1111@43.
//      REL_DONE_O=1 and RST_BUSY_O=0 @43.
//   2. RST_I pulsed high mid-RELEASE, with NRST_O=0011.
//      Expect NRST_O=0000 and REL_DONE_O=0 before the next edge; full sequence repeats.
//   3. LOCK_I=0 in RUN.
//      NRST_O=0000 at edge 3 after the fall (2 sync edges + 1).
//      Stays 0000 until LOCK_I returns, then the sequence restarts with the same spacing.
//   4. SWRST_I pulse in RUN at edge 60.
//      NRST_O=0000 @61, HOLD entry @62, NRST_O=0001 @78.
//   5. SWRST_I on the same edge as the scheduled 0011->0111 release.
//      Expect NRST_O=0000 next; the release is discarded.
//   6. NUM_DOMAINS=1, HOLD=1, GAP=1, LOCK_I=1.
//      NRST_O=1 and REL_DONE_O=1 at edge 4.
//      SWRST_I in ASSERT while LOCK_I=0 has no effect.

Source files
------------

// File: rtl/rst_sequencer_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit params_ok(input int num_domains, input int hold_cycles,
                                     input int stage_gap, input int lock_stages);
        return (num_domains >= 1) && (hold_cycles >= 1) &&
               (stage_gap >= 1) && (lock_stages >= 2);
    endfunction

endpackage

// File: rtl/lock_synchronizer.sv
// Multi-flop level synchronizer for slow asynchronous status inputs.
module lock_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic D_I,
    output logic Q_O
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw level through the chain; the async clear forces "not locked".
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], D_I};
        end
    end

    assign Q_O = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Block-level reset sequencer: waits for lock, holds all domains in reset for a
// minimum width, then releases them in ascending order with a fixed gap.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ASSERT  | all domains in reset, waiting for synchronized lock
//   HOLD    | lock seen, counting the minimum all-asserted width
//   RELEASE | releasing domains one by one, STAGE_GAP cycles apart
//   RUN     | every domain released; watching for lock loss / sw reset
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int LOCK_STAGES = 2
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   LOCK_I,
    input  logic                   SWRST_I,
    output logic [NUM_DOMAINS-1:0] NRST_O,
    output logic                   RST_BUSY_O,
    output logic                   REL_DONE_O
);

    localparam int CNT_W = $clog2(max2(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    if (!params_ok(NUM_DOMAINS, HOLD_CYCLES, STAGE_GAP, LOCK_STAGES)) begin : g_param_err
        $error("rst_sequencer: parameter below minimum (NUM_DOMAINS>=1, HOLD_CYCLES>=1, STAGE_GAP>=1, LOCK_STAGES>=2)");
    end

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_DOMAINS-1:0] nrst_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   lock_s;
    logic                   resync;

    lock_synchronizer #(
        .STAGES (LOCK_STAGES)
    ) u_lock_sync (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .D_I   (LOCK_I),
        .Q_O   (lock_s)
    );

    // Lock loss or a software request pulls every domain back into reset; ignored in ASSERT.
    assign resync = (state_q != ASSERT) && (!lock_s || SWRST_I);

    // Sequencing FSM with registered reset outputs; re-sequence takes priority over a release.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            nrst_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (resync) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            nrst_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (lock_s) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        nrst_q <= NUM_DOMAINS'(1);
                        idx_q  <= IDX_W'(1);
                        cnt_q  <= '0;
                        if (NUM_DOMAINS == 1) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        nrst_q <= nrst_q | (NUM_DOMAINS'(1) << idx_q);
                        idx_q  <= idx_q + IDX_W'(1);
                        cnt_q  <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    nrst_q <= '1;
                end
                default: begin
                    state_q <= ASSERT;
                    nrst_q  <= '0;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign NRST_O     = nrst_q;
    assign RST_BUSY_O = busy_q;
    assign REL_DONE_O = done_q;

endmodule
